// File: rtl/svfloat_unpacker.sv
// svfloat_unpacker: two-stage valid/ready pipeline splitting a packed float into class flags, sign, unbiased exponent and explicit-hidden-bit mantissa.
// Ports: clk, rst (async, active high); in_valid/in_ready/in_data = packed float input;
// out_valid/out_ready = output handshake; is_inf/is_nan/is_zero = one-hot class flags (all 0 for finite non-zero);
// d_sign = sign; d_exp = signed unbiased exponent (ewidth bits); d_man = mantissa with hidden bit (man_width+1 bits).
package svfloat;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32;
endpackage

module svfloat_unpacker #(
  parameter type float = svfloat::float32,
  parameter int ewidth = 10,
  parameter bit norm_subnormal = 1'b1,
  localparam float fz = '0,
  localparam int exp_width = $bits(fz.exponent),
  localparam int man_width = $bits(fz.mantissa)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [$bits(float)-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 is_inf,
  output logic                 is_nan,
  output logic                 is_zero,
  output logic                 d_sign,
  output logic [ewidth-1:0]    d_exp,
  output logic [man_width:0]   d_man
);
  localparam int exp_bias = 2 ** (exp_width - 1) - 1;
  localparam int min_texp = 1 - exp_bias;

  if (ewidth < exp_width + 2) begin : g_ewidth_check
    $error("svfloat_unpacker: ewidth must be at least exp_width+2");
  end

  typedef enum logic [2:0] {C_NORM, C_SUB, C_ZERO, C_INF, C_NAN} cls_t;

  float                 f;
  cls_t                 cls_in, s1_cls;
  logic                 s1_valid, s1_sign, s1_adv, s2_adv;
  logic [exp_width-1:0] s1_e;
  logic [man_width-1:0] s1_m;
  logic [ewidth-1:0]    n_exp, norm_exp, sub_exp;
  logic [man_width:0]   n_man, sub_man;
  int                   sh;

  assign f = in_data;
  assign s2_adv = !out_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // An all-ones exponent field is exp_max.
  always_comb
    cls_in = (f.exponent == '1) ? ((f.mantissa != '0) ? C_NAN : C_INF) :
             (f.exponent == '0) ? ((f.mantissa != '0) ? C_SUB : C_ZERO) : C_NORM;

  // Ascending scan: the highest set bit is seen last, leaving the smallest shift that sets the hidden bit.
  always_comb begin
    sh = 0;
    for (int i = 0; i < man_width; i++)
      if (s1_m[i]) sh = man_width - i;
    sub_man = {1'b0, s1_m} << sh;
    sub_exp = ewidth'(min_texp - sh);
    norm_exp = ewidth'(int'(s1_e) - exp_bias);
    n_exp = (s1_cls == C_NORM) ? norm_exp :
            (s1_cls == C_SUB) ? (norm_subnormal ? sub_exp : ewidth'(min_texp)) : '0;
    n_man = (s1_cls == C_NORM) ? {1'b1, s1_m} :
            (s1_cls == C_SUB && norm_subnormal) ? sub_man : {1'b0, s1_m};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_e     <= '0;
      s1_m     <= '0;
      s1_cls   <= C_ZERO;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (in_valid && s1_adv) begin
        s1_sign <= f.sign;
        s1_e    <= f.exponent;
        s1_m    <= f.mantissa;
        s1_cls  <= cls_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      is_inf    <= 1'b0;
      is_nan    <= 1'b0;
      is_zero   <= 1'b0;
      d_sign    <= 1'b0;
      d_exp     <= '0;
      d_man     <= '0;
    end else begin
      if (s2_adv) out_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        is_inf  <= s1_cls == C_INF;
        is_nan  <= s1_cls == C_NAN;
        is_zero <= s1_cls == C_ZERO;
        d_sign  <= s1_sign;
        d_exp   <= n_exp;
        d_man   <= n_man;
      end
    end
  end
endmodule

// File: tb/tb_svfloat_unpacker.sv
// tb_svfloat_unpacker: directed table-driven bench for svfloat_unpacker (float32, ewidth 10, both subnormal modes)
module tb_svfloat_unpacker;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, is_inf, is_nan, is_zero, d_sign;
  logic [9:0] d_exp;
  logic [23:0] d_man;
  logic in_ready0, out_valid0, is_inf0, is_nan0, is_zero0, d_sign0;
  logic [9:0] d_exp0;
  logic [23:0] d_man0;
  logic [38:0] obs1, obs0;

  always #5 clk = ~clk;

  svfloat_unpacker #(.ewidth(10), .norm_subnormal(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .is_inf(is_inf), .is_nan(is_nan),
    .is_zero(is_zero), .d_sign(d_sign), .d_exp(d_exp), .d_man(d_man));

  svfloat_unpacker #(.ewidth(10), .norm_subnormal(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .is_inf(is_inf0), .is_nan(is_nan0),
    .is_zero(is_zero0), .d_sign(d_sign0), .d_exp(d_exp0), .d_man(d_man0));

  assign obs1 = {out_valid, is_inf, is_nan, is_zero, d_sign, d_exp, d_man};
  assign obs0 = {out_valid0, is_inf0, is_nan0, is_zero0, d_sign0, d_exp0, d_man0};

  typedef struct {
    logic [31:0] din;
    logic [2:0]  fl;
    logic        s;
    logic [9:0]  e1;
    logic [23:0] m1;
    logic [9:0]  e0;
    logic [23:0] m0;
  } vec_t;

  vec_t tbl[13];
  int pass = 0, total = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a === x) pass++;
    else $display("FAIL %s: got %h expected %h", nm, a, x);
  endtask

  function automatic logic [38:0] ex1(input int i);
    return {1'b1, tbl[i].fl, tbl[i].s, tbl[i].e1, tbl[i].m1};
  endfunction

  function automatic logic [38:0] ex0(input int i);
    return {1'b1, tbl[i].fl, tbl[i].s, tbl[i].e0, tbl[i].m0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input int mode, input int n);
    int c = 0, nin = 0, nout = 0;
    logic [38:0] snap = '0;
    while (nout < n && c < 60) begin
      out_ready = (mode == 0) ? !(c >= 3 && c <= 5) : (c % 2 == 0);
      in_valid = nin < n;
      in_data = (nin < n) ? tbl[nin].din : 32'h0;
      #1;
      if (mode == 0 && c >= 3 && c <= 5) begin
        chk($sformatf("stall_in_ready_c%0d", c), in_ready, 0);
        if (c == 3) snap = obs1;
        else chk($sformatf("stall_hold_c%0d", c), obs1, snap);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d_item%0d", mode, nout), obs1, ex1(nout));
        nout++;
      end
      if (in_valid && in_ready) nin++;
      @(posedge clk);
      #1;
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk($sformatf("stream%0d_out_count", mode), nout, n);
    chk($sformatf("stream%0d_in_count", mode), nin, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{32'h3F800000, 3'b000, 1'b0, 10'd0,    24'h800000, 10'd0,    24'h800000};
    tbl[1]  = '{32'h7F7FFFFF, 3'b000, 1'b0, 10'd127,  24'hFFFFFF, 10'd127,  24'hFFFFFF};
    tbl[2]  = '{32'h00000001, 3'b000, 1'b0, -10'd149, 24'h800000, -10'd126, 24'h000001};
    tbl[3]  = '{32'h00400000, 3'b000, 1'b0, -10'd127, 24'h800000, -10'd126, 24'h400000};
    tbl[4]  = '{32'hFF800000, 3'b100, 1'b1, 10'd0,    24'h000000, 10'd0,    24'h000000};
    tbl[5]  = '{32'h7FC00001, 3'b010, 1'b0, 10'd0,    24'h400001, 10'd0,    24'h400001};
    tbl[6]  = '{32'h80000000, 3'b001, 1'b1, 10'd0,    24'h000000, 10'd0,    24'h000000};
    tbl[7]  = '{32'hC0490FDB, 3'b000, 1'b1, 10'd1,    24'hC90FDB, 10'd1,    24'hC90FDB};
    tbl[8]  = '{32'h007FFFFF, 3'b000, 1'b0, -10'd127, 24'hFFFFFE, -10'd126, 24'h7FFFFF};
    tbl[9]  = '{32'h7F800001, 3'b010, 1'b0, 10'd0,    24'h000001, 10'd0,    24'h000001};
    tbl[10] = '{32'h00800000, 3'b000, 1'b0, -10'd126, 24'h800000, -10'd126, 24'h800000};
    tbl[11] = '{32'h00000003, 3'b000, 1'b0, -10'd148, 24'hC00000, -10'd126, 24'h000003};
    tbl[12] = '{32'h00000000, 3'b001, 1'b0, 10'd0,    24'h000000, 10'd0,    24'h000000};

    #2;
    chk("reset_outputs", obs1, 0);
    #10;
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    tick();

    for (int i = 0; i < 13; i++) begin
      in_data = tbl[i].din;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data = 32'hDEADBEEF;
      chk($sformatf("latency_vec%0d", i), out_valid, 0);
      tick();
      chk($sformatf("vec%0d_norm1", i), obs1, ex1(i));
      chk($sformatf("vec%0d_norm0", i), obs0, ex0(i));
    end
    tick();

    run_stream(0, 6);
    run_stream(1, 8);
    tick();

    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = tbl[0].din;
    tick();
    in_data = tbl[1].din;
    tick();
    in_valid = 1'b0;
    chk("preflight_full", {out_valid, in_ready}, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", obs1, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_reset_ready", {in_ready, out_valid}, 2'b10);
    in_data = tbl[7].din;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("post_reset_no_stale", out_valid, 0);
    tick();
    chk("post_reset_item", obs1, ex1(7));
    tick();
    chk("post_reset_drained", out_valid, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
